// File: rtl/compact_bf_pipe.sv
// Pipelined radix-2^2 butterfly (forward CT / inverse GS per sample), latency 2*(MUL_LAT+1) en-qualified cycles.
// en=0 freezes all state; define BF_HALVE_EN to halve every inverse-mode stage output mod Q.

module compact_bf_pe #(
  parameter int W       = 12,
  parameter int Q       = 3329,
  parameter int MUL_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         mode,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] w,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);
  localparam logic [W:0]     QN = (W+1)'(Q);
  localparam logic [2*W-1:0] QP = (2*W)'(Q);

  function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= QN) s = s - QN;
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] d;
    if (a >= b) d = {1'b0, a} - {1'b0, b};
    else        d = {1'b0, a} + QN - {1'b0, b};
    return d[W-1:0];
  endfunction

`ifdef BF_HALVE_EN
  function automatic logic [W-1:0] halve(input logic [W-1:0] a);
    logic [W:0] s;
    s = a[0] ? ({1'b0, a} + QN) : {1'b0, a};
    return s[W:1];
  endfunction
`endif

  // Inverse does its add/sub before the entry register, forward after the
  // multiplier, so both modes share one multiplier and have equal latency.
  logic [W-1:0]   x_d [MUL_LAT+1];
  logic [MUL_LAT:0] m_d;
  logic [W-1:0]   y_r;
  logic [W-1:0]   w_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= MUL_LAT; i++) x_d[i] <= '0;
      m_d <= '0;
      y_r <= '0;
      w_r <= '0;
    end else if (en) begin
      x_d[0] <= mode ? mod_add(x, y) : x;
      y_r    <= mode ? mod_sub(x, y) : y;
      w_r    <= w;
      m_d    <= {m_d[MUL_LAT-1:0], mode};
      for (int i = 1; i <= MUL_LAT; i++) x_d[i] <= x_d[i-1];
    end
  end

  logic [2*W-1:0] prod;
  logic [W-1:0]   p;

  assign prod = {{W{1'b0}}, y_r} * {{W{1'b0}}, w_r};

  generate
    if (MUL_LAT == 1) begin : g_mul1
      logic [W-1:0] r;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)     r <= '0;
        else if (en) r <= W'(prod % QP);
      end
      assign p = r;
    end else begin : g_muln
      // Product registered first, reduction next, then plain delay to MUL_LAT.
      logic [2*W-1:0] pr;
      logic [W-1:0]   r [MUL_LAT-1];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pr <= '0;
          for (int i = 0; i < MUL_LAT-1; i++) r[i] <= '0;
        end else if (en) begin
          pr   <= prod;
          r[0] <= W'(pr % QP);
          for (int i = 1; i < MUL_LAT-1; i++) r[i] <= r[i-1];
        end
      end
      assign p = r[MUL_LAT-2];
    end
  endgenerate

  logic         m_o;
  logic [W-1:0] x_o;
  logic [W-1:0] hi_c;
  logic [W-1:0] lo_c;

  always_comb begin
    m_o  = m_d[MUL_LAT];
    x_o  = x_d[MUL_LAT];
    hi_c = x_o;
    lo_c = p;
    if (!m_o) begin
      hi_c = mod_add(x_o, p);
      lo_c = mod_sub(x_o, p);
    end
  end

`ifdef BF_HALVE_EN
  assign hi = m_o ? halve(hi_c) : hi_c;
  assign lo = m_o ? halve(lo_c) : lo_c;
`else
  assign hi = hi_c;
  assign lo = lo_c;
`endif

endmodule

module compact_bf_pipe #(
  parameter int DATA_WIDTH = 12,
  parameter int Q          = 3329,
  parameter int MUL_LAT    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic                  mode,
  input  logic [DATA_WIDTH-1:0] u0,
  input  logic [DATA_WIDTH-1:0] v0,
  input  logic [DATA_WIDTH-1:0] u1,
  input  logic [DATA_WIDTH-1:0] v1,
  input  logic [DATA_WIDTH-1:0] wa1,
  input  logic [DATA_WIDTH-1:0] wa2,
  input  logic [DATA_WIDTH-1:0] wa3,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] bf_0_upper,
  output logic [DATA_WIDTH-1:0] bf_0_lower,
  output logic [DATA_WIDTH-1:0] bf_1_upper,
  output logic [DATA_WIDTH-1:0] bf_1_lower,
  output logic                  busy
);
  localparam int L = MUL_LAT + 1;

  logic [2*L-1:0]        vld_sr;
  logic [L-1:0]          mode_sr;
  logic [DATA_WIDTH-1:0] tw0_sr [L];
  logic [DATA_WIDTH-1:0] tw1_sr [L];

  // Stage-2 twiddles are selected by mode at entry and carried with the sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sr  <= '0;
      mode_sr <= '0;
      for (int i = 0; i < L; i++) begin
        tw0_sr[i] <= '0;
        tw1_sr[i] <= '0;
      end
    end else if (en) begin
      vld_sr    <= {vld_sr[2*L-2:0], in_valid};
      mode_sr   <= {mode_sr[L-2:0], mode};
      tw0_sr[0] <= mode ? wa2 : wa1;
      tw1_sr[0] <= mode ? wa2 : wa3;
      for (int i = 1; i < L; i++) begin
        tw0_sr[i] <= tw0_sr[i-1];
        tw1_sr[i] <= tw1_sr[i-1];
      end
    end
  end

  assign out_valid = vld_sr[2*L-1];
  assign busy      = |vld_sr;

  logic [DATA_WIDTH-1:0] w_s1_0;
  logic [DATA_WIDTH-1:0] w_s1_1;
  logic [DATA_WIDTH-1:0] a0, a1, b0, b1;

  assign w_s1_0 = mode ? wa1 : wa2;
  assign w_s1_1 = mode ? wa3 : wa2;

  compact_bf_pe #(.W(DATA_WIDTH), .Q(Q), .MUL_LAT(MUL_LAT)) u_s1_pe0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .x(u0), .y(v0), .w(w_s1_0), .hi(a0), .lo(a1)
  );

  compact_bf_pe #(.W(DATA_WIDTH), .Q(Q), .MUL_LAT(MUL_LAT)) u_s1_pe1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .x(u1), .y(v1), .w(w_s1_1), .hi(b0), .lo(b1)
  );

  compact_bf_pe #(.W(DATA_WIDTH), .Q(Q), .MUL_LAT(MUL_LAT)) u_s2_pe0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode_sr[L-1]),
    .x(a0), .y(b0), .w(tw0_sr[L-1]), .hi(bf_0_upper), .lo(bf_0_lower)
  );

  compact_bf_pe #(.W(DATA_WIDTH), .Q(Q), .MUL_LAT(MUL_LAT)) u_s2_pe1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode_sr[L-1]),
    .x(a1), .y(b1), .w(tw1_sr[L-1]), .hi(bf_1_upper), .lo(bf_1_lower)
  );

endmodule

// File: tb/tb_compact_bf_pipe.sv
// Scoreboard bench for compact_bf_pipe: expectations queued at drive time, checked when out_valid is consumed.
module tb_compact_bf_pipe;
  localparam int W   = 12;
  localparam int Q   = 3329;
  localparam int LAT = 6;
`ifdef BF_HALVE_EN
  localparam bit HALVE = 1'b1;
`else
  localparam bit HALVE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, en, in_valid, mode;
  logic [W-1:0] u0, v0, u1, v1, wa1, wa2, wa3;
  logic out_valid, busy;
  logic [W-1:0] bf_0_upper, bf_0_lower, bf_1_upper, bf_1_lower;

  always #5 clk = ~clk;

  compact_bf_pipe #(.DATA_WIDTH(W), .Q(Q), .MUL_LAT(2)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .mode(mode),
    .u0(u0), .v0(v0), .u1(u1), .v1(v1),
    .wa1(wa1), .wa2(wa2), .wa3(wa3),
    .out_valid(out_valid),
    .bf_0_upper(bf_0_upper), .bf_0_lower(bf_0_lower),
    .bf_1_upper(bf_1_upper), .bf_1_lower(bf_1_lower),
    .busy(busy)
  );

  typedef struct {
    int b0u;
    int b0l;
    int b1u;
    int b1l;
    int issue;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   ecnt     = 0;

  always @(posedge clk) if (en && !rst) ecnt <= ecnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int madd(input int a, input int b); return (a + b) % Q; endfunction
  function automatic int msub(input int a, input int b); return (a - b + Q) % Q; endfunction
  function automatic int mmul(input int a, input int b); return (a * b) % Q; endfunction
  function automatic int hv(input int a);
    if (HALVE) return (a % 2 == 1) ? (a + Q) / 2 : a / 2;
    return a;
  endfunction

  function automatic exp_t mk(input int p, input int q, input int r, input int s);
    exp_t e;
    e.b0u = p; e.b0l = q; e.b1u = r; e.b1l = s; e.issue = 0;
    return e;
  endfunction

  function automatic exp_t model(input logic m, input int x0, input int y0, input int x1, input int y1,
                                 input int w1, input int w2, input int w3);
    int a0, a1, b0, b1, t0, t1;
    if (!m) begin
      t0 = mmul(w2, y0);
      t1 = mmul(w2, y1);
      a0 = madd(x0, t0); a1 = msub(x0, t0);
      b0 = madd(x1, t1); b1 = msub(x1, t1);
      return mk(madd(a0, mmul(w1, b0)), msub(a0, mmul(w1, b0)),
                madd(a1, mmul(w3, b1)), msub(a1, mmul(w3, b1)));
    end
    a0 = hv(madd(x0, y0)); a1 = hv(mmul(msub(x0, y0), w1));
    b0 = hv(madd(x1, y1)); b1 = hv(mmul(msub(x1, y1), w3));
    return mk(hv(madd(a0, b0)), hv(mmul(msub(a0, b0), w2)),
              hv(madd(a1, b1)), hv(mmul(msub(a1, b1), w2)));
  endfunction

  task automatic send_raw(input logic m, input int x0, input int y0, input int x1, input int y1,
                          input int w1, input int w2, input int w3, input exp_t e);
    mode = m;
    u0 = x0[W-1:0]; v0 = y0[W-1:0]; u1 = x1[W-1:0]; v1 = y1[W-1:0];
    wa1 = w1[W-1:0]; wa2 = w2[W-1:0]; wa3 = w3[W-1:0];
    in_valid = 1'b1;
    e.issue = ecnt;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic m, input int x0, input int y0, input int x1, input int y1,
                      input int w1, input int w2, input int w3);
    send_raw(m, x0, y0, x1, y1, w1, w2, w3, model(m, x0, y0, x1, y1, w1, w2, w3));
  endtask

  function automatic int rnd();
    return int'($urandom_range(0, Q - 1));
  endfunction

  task automatic send_rand(input logic m);
    send(m, rnd(), rnd(), rnd(), rnd(), rnd(), rnd(), rnd());
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    check(tag, 32'(exp_q.size()), 0);
    idle(2);
    check({tag, "_busy_idle"}, 32'(busy), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_bf_0_upper"}, 32'(bf_0_upper), 0);
    check({tag, "_bf_0_lower"}, 32'(bf_0_lower), 0);
    check({tag, "_bf_1_upper"}, 32'(bf_1_upper), 0);
    check({tag, "_bf_1_lower"}, 32'(bf_1_lower), 0);
  endtask

  // Outputs are consumed only on cycles where en advances the pipe.
  always @(negedge clk) begin
    if (!rst && en && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("latency", 32'(ecnt - mon_e.issue), LAT);
        check("bf_0_upper", 32'(bf_0_upper), 32'(mon_e.b0u));
        check("bf_0_lower", 32'(bf_0_lower), 32'(mon_e.b0l));
        check("bf_1_upper", 32'(bf_1_upper), 32'(mon_e.b1u));
        check("bf_1_lower", 32'(bf_1_lower), 32'(mon_e.b1l));
      end
    end
  end

  initial begin
    rst = 1'b0; en = 1'b1; in_valid = 1'b0; mode = 1'b0;
    u0 = '0; v0 = '0; u1 = '0; v1 = '0; wa1 = '0; wa2 = '0; wa3 = '0;
    #1 rst = 1'b1;
    #2;
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed forward cases with hand-computed results.
    send_raw(1'b0, 1, 2, 3, 4, 1, 1, 1, mk(10, 3325, 3327, 0));
    wait_drain("fwd_basic_drain");
    send_raw(1'b0, 0, 1, 0, 0, 1, 17, 1, mk(17, 17, 3312, 3312));
    wait_drain("fwd_twiddle_drain");

    // Directed inverse case.
    if (HALVE) send_raw(1'b1, 1, 0, 0, 0, 1, 1, 1, mk(2497, 2497, 2497, 2497));
    else       send_raw(1'b1, 1, 2, 3, 4, 1, 1, 1, mk(10, 3325, 3327, 0));
    wait_drain("inv_basic_drain");

    // Back-to-back alternating modes.
    for (int i = 0; i < 20; i++) send_rand(i[0]);
    wait_drain("stream_drain");

    // Stall with 4 samples in flight; the oldest sits at the output while frozen.
    for (int i = 0; i < 4; i++) send_rand(i[0]);
    idle(2);
    en = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_out_valid", 32'(out_valid), 1);
      check("stall_busy", 32'(busy), 1);
      check("stall_bf_0_upper", 32'(bf_0_upper), 32'(exp_q[0].b0u));
      check("stall_bf_1_lower", 32'(bf_1_lower), 32'(exp_q[0].b1l));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    en = 1'b1;
    wait_drain("stall_drain");

    // Asynchronous reset between edges with 5 samples in flight.
    for (int i = 0; i < 5; i++) send_rand(i[0]);
    idle(1);
    #3 rst = 1'b1;
    #1;
    check_zero("midrst");
    exp_q.delete();
    @(negedge clk);
    check_zero("midrst_held");
    @(posedge clk); #1;
    rst = 1'b0;
    idle(12);
    check("post_rst_quiet_busy", 32'(busy), 0);
    send_rand(1'b0);
    wait_drain("post_rst_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
